readout_arbiter: RTL and testbench
==================================

# readout_arbiter

- Round-robin, burst-limited arbiter that drains `NumCh` per-channel readout FIFOs into one registered valid/ready output stream.
- Each forwarded word is tagged with its source channel.
- Sits in the readout network between the per-sensor show-ahead FIFOs (`q` valid whenever not empty, pop on `rdreq`) and the uplink serializer.

## Interface
- `NumCh`, 4: number of requesting FIFOs; must be ≥ 2.
- `DataWidth`, 8: FIFO word width.
- `MaxBurst`, 4: maximum words popped per grant; must be ≥ 1.
- `ChW`, `$clog2(NumCh)`: channel tag width (derived; do not override).

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `fifo_empty_i`  in  NumCh  per-channel FIFO empty flags.
- `fifo_q_i`  in  NumCh*DataWidth  head words; channel c occupies `[c*DataWidth +: DataWidth]`.
- `fifo_rdreq_o`  out  NumCh  one-hot-or-zero pop strobes.
- `out_valid_o`  out  1  output register holds a word.
- `out_ready_i`  in  1  downstream accepts the word this cycle.
- `out_data_o`  out  DataWidth  forwarded word.
- `out_ch_o`  out  ChW  source channel of `out_data_o`.
- `busy_o`  out  1  FSM is not in IDLE.

## Operation
- FSM states: IDLE, XFER.
  - IDLE: if any `fifo_empty_i[c]` is 0, select the first non-empty channel searching from `last+1` modulo NumCh upward; latch it into `grant`, clear `bcnt`, go to XFER. Otherwise stay in IDLE.
  - XFER: `pop = !fifo_empty_i[grant] && (!out_valid_o || out_ready_i)`.
    - `fifo_rdreq_o[grant] = pop`; all other bits are 0. `fifo_rdreq_o` is combinational from state and inputs and is 0 in IDLE.
    - On pop: output register loads `fifo_q_i[grant]` and `grant`, `bcnt` increments.
  - XFER → IDLE when:
    - a pop occurs with `bcnt == MaxBurst-1`, or
    - `fifo_empty_i[grant]` is 1 (no pop that cycle).
    - On leaving, `last <= grant`.
- Output register:
  - `out_valid_o` sets on pop.
  - It clears on `out_ready_i && !pop`.
  - It holds while `out_valid_o && !out_ready_i`.
  - Data and channel are stable while valid and not accepted.
- A channel that becomes empty mid-burst forfeits the rest of its burst. Arbitration resumes in IDLE from `grant+1`.
- Simultaneous accept and pop in the same cycle: the new word replaces the old one, so there is no bubble.
- `bcnt` width is `$clog2(MaxBurst+1)`; it never wraps because the exit condition is checked first.

## Timing
- Reset values:
  - state IDLE, `last = NumCh-1` (first grant scans from channel 0), `grant = 0`, `bcnt = 0`.
  - `out_valid_o = 0`, `out_data_o = 0`, `out_ch_o = 0`, `busy_o = 0`, `fifo_rdreq_o = 0`.
- Latency: one IDLE arbitration cycle, then the first pop. The word is on `out_*` the cycle after the pop.
- Throughput: one word per cycle within a burst when `out_ready_i` is held high. Each re-arbitration costs one idle cycle.
- Reset asserted mid-burst: all state returns to reset values immediately. The word in the output register is dropped. Words remaining in the FIFO are untouched.
- `fifo_empty_i` and `fifo_q_i` are sampled combinationally in the same cycle as the pop. The FIFO updates its pointer on that same edge.

## Configuration
- `READOUT_ARB_STATS_EN` defined:
  - Adds output port `word_cnt_o` [31:0], a saturating count of accepted words (`out_valid_o && out_ready_i`).
  - Adds input `stats_clr_i`, which zeros the counter synchronously.
  - Clear takes priority over an increment in the same cycle.
  - Reset value is 0.
- Undefined: neither port exists and no counter logic is synthesized. All other behaviour is identical.

## Structure
- Package `readout_pkg`:
  - state enum (IDLE = 0, XFER = 1),
  - `rr_next` helper function,
  - `DataWidth` default as a shared constant.
- Sub-module `rr_picker`: a combinational round-robin find-first.
  - Inputs: request vector, `last` index.
  - Outputs: `gnt_idx` and `any_req`.
  - It is reused by the future uplink mux.

## Test plan
- Only channel 2 non-empty, holding 3 words A, B, C, with ready high:
  - IDLE one cycle, then pops on three consecutive cycles.
  - `out_data_o` shows A, B, C with `out_ch_o = 2`.
  - Back to IDLE on the fourth cycle.
- All four channels each holding 6 words, with MaxBurst = 4:
  - Grant order 0, 1, 2, 3, 0, 1, 2, 3.
  - Channels 0–3 first get 4 words each, then 2 words each.
  - One IDLE cycle between bursts; 24 words total.
- Backpressure, `out_ready_i` low for 5 cycles mid-burst:
  - No `fifo_rdreq_o` pulse during the stall.
  - `out_data_o` stable.
  - Burst resumes without loss or duplication.
- Channel 1 empties after 2 of 4 words:
  - XFER exits with `bcnt = 2`.
  - The next grant goes to channel 2 even if channel 1 refills in the same cycle.
- `rst` pulsed during the third pop of a burst:
  - Outputs drop to reset values asynchronously.
  - After release, arbitration restarts at channel 0.
- With `READOUT_ARB_STATS_EN`: 10 accepted words → `word_cnt_o = 10`. `stats_clr_i` together with an accept → 0.

Source files
------------

// File: rtl/readout_pkg.sv
// Shared types and helpers for the readout arbiter and its round-robin picker.
// Optional feature macro used by the top: READOUT_ARB_STATS_EN.
package readout_pkg;

    // Default FIFO word width shared across the readout network.
    localparam int DATA_WIDTH = 8;

    // Arbiter FSM states.
    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    // Next index in a ring of n entries.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/readout_arbiter_if.sv
// Bundle of the FIFO-side and stream-side signals of the readout arbiter.
// master: the arbiter side; slave: the FIFOs plus downstream consumer.
interface readout_arbiter_if
    import readout_pkg::*;
#(
    parameter int NumCh     = 4,
    parameter int DataWidth = DATA_WIDTH,
    parameter int ChW       = $clog2(NumCh)
);
    logic [NumCh-1:0]           fifo_empty_i;
    logic [NumCh*DataWidth-1:0] fifo_q_i;
    logic [NumCh-1:0]           fifo_rdreq_o;
    logic                       out_valid_o;
    logic                       out_ready_i;
    logic [DataWidth-1:0]       out_data_o;
    logic [ChW-1:0]             out_ch_o;
    logic                       busy_o;

    modport master (
        input  fifo_empty_i, fifo_q_i, out_ready_i,
        output fifo_rdreq_o, out_valid_o, out_data_o, out_ch_o, busy_o
    );

    modport slave (
        output fifo_empty_i, fifo_q_i, out_ready_i,
        input  fifo_rdreq_o, out_valid_o, out_data_o, out_ch_o, busy_o
    );
endinterface

// File: rtl/readout_arbiter_rr_picker.sv
// Combinational round-robin find-first: returns the first requesting index
// searching upward from last+1 (wrapping), plus whether any request exists.
module rr_picker
    import readout_pkg::*;
#(
    parameter int NumCh = 4,
    parameter int ChW   = $clog2(NumCh)
) (
    input  logic [NumCh-1:0] req_i,
    input  logic [ChW-1:0]   last_i,
    output logic [ChW-1:0]   gnt_idx_o,
    output logic             any_req_o
);

    // Walk the ring once starting just after last; keep the first hit.
    always_comb begin
        int w_cand;
        gnt_idx_o = '0;
        any_req_o = 1'b0;
        w_cand    = rr_next(int'(last_i), NumCh);
        for (int k = 0; k < NumCh; k++) begin
            if (!any_req_o && req_i[w_cand[ChW-1:0]]) begin
                gnt_idx_o = w_cand[ChW-1:0];
                any_req_o = 1'b1;
            end
            w_cand = rr_next(w_cand, NumCh);
        end
    end

endmodule

// File: rtl/readout_arbiter.sv
// Round-robin, burst-limited arbiter draining NumCh show-ahead FIFOs into one
// registered valid/ready stream tagged with the source channel.
// Optional macro READOUT_ARB_STATS_EN adds a saturating accepted-word counter.
module readout_arbiter
    import readout_pkg::*;
#(
    parameter int NumCh     = 4,
    parameter int DataWidth = DATA_WIDTH,
    parameter int MaxBurst  = 4,
    parameter int ChW       = $clog2(NumCh)
) (
    input  logic               clk,
    input  logic               rst,
`ifdef READOUT_ARB_STATS_EN
    input  logic               stats_clr_i,
    output logic [31:0]        word_cnt_o,
`endif
    readout_arbiter_if.master  bus
);

    localparam int             BcW      = $clog2(MaxBurst + 1);
    localparam logic [BcW-1:0] LastBeat = BcW'(MaxBurst - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ChW-1:0]       r_last;
    logic [ChW-1:0]       r_grant;
    logic [BcW-1:0]       r_bcnt;
    logic                 r_out_valid;
    logic [DataWidth-1:0] r_out_data;
    logic [ChW-1:0]       r_out_ch;

    logic [NumCh-1:0]     w_req;
    logic [ChW-1:0]       w_pick;
    logic                 w_any_req;
    logic                 w_grant_empty;
    logic [DataWidth-1:0] w_head;
    logic                 w_pop;
    logic                 w_leave;
    logic [NumCh-1:0]     w_rdreq;

    assign w_req = ~bus.fifo_empty_i;

    rr_picker #(
        .NumCh (NumCh),
        .ChW   (ChW)
    ) u_picker (
        .req_i     (w_req),
        .last_i    (r_last),
        .gnt_idx_o (w_pick),
        .any_req_o (w_any_req)
    );

    // Granted FIFO's head/empty and the pop condition (stall-aware, no bubble).
    always_comb begin
        w_grant_empty = bus.fifo_empty_i[r_grant];
        w_head        = bus.fifo_q_i[int'(r_grant)*DataWidth +: DataWidth];
        w_pop         = (r_state == XFER) && !w_grant_empty &&
                        (!r_out_valid || bus.out_ready_i);
    end

    // Next state, pop strobes and burst-exit decision.
    always_comb begin
        w_state_nxt = r_state;
        w_rdreq     = '0;
        w_leave     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = XFER;
                end
            end
            XFER: begin
                w_rdreq[r_grant] = w_pop;
                // Exit on the last allowed beat, or forfeit when the FIFO runs dry.
                if (w_grant_empty || (w_pop && (r_bcnt == LastBeat))) begin
                    w_state_nxt = IDLE;
                    w_leave     = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM state, granted channel, burst counter and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_last  <= ChW'(NumCh - 1);
            r_grant <= '0;
            r_bcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == IDLE) && w_any_req) begin
                r_grant <= w_pick;
                r_bcnt  <= '0;
            end
            if (w_pop) begin
                r_bcnt <= r_bcnt + 1'b1;
            end
            if (w_leave) begin
                r_last <= r_grant;
            end
        end
    end

    // Output register: load on pop, drop on accept, hold under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
        end else if (w_pop) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_head;
            r_out_ch    <= r_grant;
        end else if (bus.out_ready_i) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.fifo_rdreq_o = w_rdreq;
    assign bus.out_valid_o  = r_out_valid;
    assign bus.out_data_o   = r_out_data;
    assign bus.out_ch_o     = r_out_ch;
    assign bus.busy_o       = (r_state != IDLE);

`ifdef READOUT_ARB_STATS_EN
    logic [31:0] r_word_cnt;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    // Accepted-word counter; clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word_cnt <= '0;
        end else if (stats_clr_i) begin
            r_word_cnt <= '0;
        end else if (r_out_valid && bus.out_ready_i) begin
            r_word_cnt <= sat_inc(r_word_cnt);
        end
    end

    assign word_cnt_o = r_word_cnt;
`endif

endmodule

// File: tb/tb_readout_arbiter.sv
// Scoreboard bench for readout_arbiter: FIFO queues feed the DUT, a
// round-robin/burst reference model predicts the tagged word stream, and a
// negedge monitor compares every accepted word against the expected queue.
module tb_readout_arbiter;
    import readout_pkg::*;

    localparam int NCH = 4;
    localparam int DW  = 8;
    localparam int MB  = 4;

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    readout_arbiter_if #(.NumCh(NCH), .DataWidth(DW)) bus ();

`ifdef READOUT_ARB_STATS_EN
    logic        stats_clr;
    logic [31:0] word_cnt;
`endif

    readout_arbiter #(
        .NumCh     (NCH),
        .DataWidth (DW),
        .MaxBurst  (MB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef READOUT_ARB_STATS_EN
        .stats_clr_i (stats_clr),
        .word_cnt_o  (word_cnt),
`endif
        .bus         (bus)
    );

    byte_q_t    fq[NCH];
    byte_q_t    mq[NCH];
    exp_t       exp_q[$];
    int         m_last;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_pops   = 0;
    int         acc_cnt  = 0;
    logic [3:0] last_snap;
    bit         rdy_rand;
    bit         stall_prev;
    logic [7:0] prev_data;
    logic [1:0] prev_ch;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic int fifo_total();
        int t = 0;
        for (int c = 0; c < NCH; c++) t += fq[c].size();
        return t;
    endfunction

    task automatic drive();
        for (int c = 0; c < NCH; c++) begin
            bus.fifo_empty_i[c] = (fq[c].size() == 0);
            bus.fifo_q_i[c*DW +: DW] = (fq[c].size() > 0) ? fq[c][0] : 8'h00;
        end
    endtask

    // Word goes into the FIFO and into the reference model's view of it.
    task automatic load(input int c, input logic [7:0] d);
        fq[c].push_back(d);
        mq[c].push_back(d);
    endtask

    task automatic push_exp(input int c, input logic [7:0] d);
        exp_t e;
        e.ch   = 2'(c);
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Reference: bursts of min(MaxBurst, remaining) words, channels visited in
    // ring order starting after the previously served channel.
    task automatic model_run();
        int  ch;
        int  n;
        int  t;
        bit  found;
        for (int it = 0; it < 200; it++) begin
            found = 1'b0;
            ch    = 0;
            for (int k = 1; k <= NCH; k++) begin
                t = (m_last + k) % NCH;
                if (!found && mq[t].size() > 0) begin
                    found = 1'b1;
                    ch    = t;
                end
            end
            if (!found) break;
            n = (mq[ch].size() < MB) ? mq[ch].size() : MB;
            for (int i = 0; i < n; i++) push_exp(ch, mq[ch].pop_front());
            m_last = ch;
        end
    endtask

    // One clock: entered and left at posedge+1; pops follow the strobe seen
    // just before the edge, like a real show-ahead FIFO.
    task automatic tick();
        logic [7:0] tmp;
        #8;
        last_snap = bus.fifo_rdreq_o;
        #2;
        for (int c = 0; c < NCH; c++) begin
            if (last_snap[c]) begin
                if (fq[c].size() > 0) begin
                    tmp = fq[c].pop_front();
                    n_pops++;
                end else begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pop_empty: got rdreq on empty ch %0d, expected none", c);
                end
            end
        end
        if (rdy_rand) bus.out_ready_i = ($urandom_range(0, 3) != 0);
        drive();
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_q.size() != 0 || fifo_total() != 0 || bus.busy_o) && k < 400) begin
            tick();
            k++;
        end
        check("drain_exp_left", 32'(exp_q.size()), 32'd0);
        check("drain_busy", 32'(bus.busy_o), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(bus.out_valid_o), 32'd0);
        check({tag, "_data"},  32'(bus.out_data_o),  32'd0);
        check({tag, "_ch"},    32'(bus.out_ch_o),    32'd0);
        check({tag, "_busy"},  32'(bus.busy_o),      32'd0);
        check({tag, "_rdreq"}, 32'(bus.fifo_rdreq_o), 32'd0);
    endtask

    // Monitor: compare accepted words, and check hold/no-pop under backpressure.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stall_prev = 1'b0;
            acc_cnt    = 0;
        end else begin
            if (bus.out_valid_o && stall_prev) begin
                check("hold_data", 32'(bus.out_data_o), 32'(prev_data));
                check("hold_ch",   32'(bus.out_ch_o),   32'(prev_ch));
            end
            if (bus.out_valid_o && !bus.out_ready_i)
                check("stall_rdreq", 32'(bus.fifo_rdreq_o), 32'd0);
            if (bus.out_valid_o && bus.out_ready_i) begin
                acc_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got ch %0d data %0h, expected no word",
                             bus.out_ch_o, bus.out_data_o);
                end else begin
                    e = exp_q.pop_front();
                    check("word_ch",   32'(bus.out_ch_o),   32'(e.ch));
                    check("word_data", 32'(bus.out_data_o), 32'(e.data));
                end
            end
            stall_prev = bus.out_valid_o && !bus.out_ready_i;
            prev_data  = bus.out_data_o;
            prev_ch    = bus.out_ch_o;
        end
    end

    initial begin
        logic [3:0] exp_req[5];
        int         p0;
        int         a0;
        int         k;
        rst             = 1'b1;
        rdy_rand        = 1'b0;
        bus.out_ready_i = 1'b1;
`ifdef READOUT_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        m_last = NCH - 1;
        drive();
        #6;
        check_reset_outputs("reset");
        tick();
        tick();
        rst = 1'b0;

        // Single channel, three words: one arbitration cycle then back-to-back pops.
        load(2, 8'hA1); load(2, 8'hB2); load(2, 8'hC3);
        model_run();
        drive();
        exp_req = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("lat_rdreq_c%0d", i), 32'(last_snap), 32'(exp_req[i]));
        end
        check("lat_idle_again", 32'(bus.busy_o), 32'd0);
        drain();

        // Four channels of six words: bursts of four, then two, round robin.
        for (int c = 0; c < NCH; c++)
            for (int i = 0; i < 6; i++) load(c, 8'((c << 4) | i));
        model_run();
        p0 = n_pops;
        a0 = acc_cnt;
        drive();
        drain();
        check("rr_total_pops", 32'(n_pops - p0), 32'd24);
        check("rr_total_words", 32'(acc_cnt - a0), 32'd24);

        // Backpressure for five cycles in the middle of a burst.
        for (int i = 0; i < 6; i++) load(0, 8'h50 + 8'(i));
        model_run();
        a0 = acc_cnt;
        drive();
        k = 0;
        while ((acc_cnt - a0) < 2 && k < 20) begin
            tick();
            k++;
        end
        check("bp_reached_mid", 32'(acc_cnt - a0 >= 2), 32'd1);
        bus.out_ready_i = 1'b0;
        p0 = n_pops;
        for (int i = 0; i < 5; i++) tick();
        check("bp_stall_pops", 32'(n_pops - p0), 32'd0);
        check("bp_valid_held", 32'(bus.out_valid_o), 32'd1);
        bus.out_ready_i = 1'b1;
        drain();

        // Channel 1 runs dry after two words and refills as the burst ends.
        fq[1].push_back(8'h11); fq[1].push_back(8'h12);
        fq[2].push_back(8'h21); fq[2].push_back(8'h22);
        push_exp(1, 8'h11); push_exp(1, 8'h12);
        push_exp(2, 8'h21); push_exp(2, 8'h22);
        push_exp(1, 8'h13);
        drive();
        k = 0;
        while (fq[1].size() != 0 && k < 20) begin
            tick();
            k++;
        end
        tick();
        check("empty_exit_idle", 32'(bus.busy_o), 32'd0);
        fq[1].push_back(8'h13);
        drive();
        drain();
        m_last = 1;

        // Reset asserted while the third pop of a burst is being requested.
        for (int i = 0; i < 5; i++) fq[2].push_back(8'h30 + 8'(i));
        push_exp(2, 8'h30);
        drive();
        k = 0;
        while (fq[2].size() != 3 && k < 20) begin
            tick();
            k++;
        end
        check("rst_third_pop_req", 32'(bus.fifo_rdreq_o), 32'h4);
        rst = 1'b1;
        fq[0].push_back(8'h0F);
        drive();
        #1;
        check_reset_outputs("midrst");
        #9;
        rst = 1'b0;
        push_exp(0, 8'h0F);
        push_exp(2, 8'h32); push_exp(2, 8'h33); push_exp(2, 8'h34);
        drain();
        check("rst_fifo_kept_pops", 32'(fifo_total()), 32'd0);
        m_last = 2;

        // Randomised contents with random downstream readiness.
        rdy_rand = 1'b1;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < NCH; c++) begin
                k = $urandom_range(0, 9);
                for (int i = 0; i < k; i++) load(c, 8'($urandom));
            end
            model_run();
            drive();
            drain();
        end
        rdy_rand        = 1'b0;
        bus.out_ready_i = 1'b1;
        drive();

`ifdef READOUT_ARB_STATS_EN
        check("stats_count", word_cnt, 32'(acc_cnt));
        load(3, 8'hE1); load(3, 8'hE2);
        model_run();
        drive();
        k = 0;
        while (!bus.out_valid_o && k < 10) begin
            tick();
            k++;
        end
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        check("stats_clr_wins", word_cnt, 32'd0);
        a0 = acc_cnt;
        drain();
        check("stats_after_clr", word_cnt, 32'(acc_cnt - a0));
`endif

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

    // Absolute guard so the bench always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
